// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Arbitrates one instruction-fetch port and one data port onto a single
//   memory port. A request is granted from IDLE, its address, write data and
//   attributes are latched, and the memory port is driven only from those
//   latches until mready or the timeout abort completes the transaction.
//
//   Optional feature (macro MEMARB_RR_EN):
//     defined   - when both requests are pending in IDLE, the port that was
//                 not served by the last completed transaction is granted.
//     undefined - fixed priority, data port always wins.
//
//   Ports
//     clk, reset            clock, asynchronous active-high reset
//     ireq, iadr            fetch request (held until iack), fetch address
//     irdata, iack          fetch data (mrdata[31:0]), one-cycle completion
//     dreq, dwe, dtype      data request, 1=write, 1=doubleword
//     dadr, dwdata          data address, write data
//     drdata, dack          data read data, one-cycle completion
//     mreq, mwe, mtype      memory request, write enable, size
//     madr, mwdata          memory address, write data
//     mrdata, mready        memory read data, completion strobe
//     istall, dstall        request pending and not yet acknowledged
//     timeout               sticky abort flag
//
//   State table
//     IDLE   | no transaction; arbitration happens here
//     IFETCH | fetch transaction in progress, mreq=1, mwe=0
//     DATA   | data transaction in progress, mreq=1

module mem_arbiter #(
   parameter int N          = 64,
   parameter int TMO_CYCLES = 255
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         ireq,
   input  logic [31:0]  iadr,
   output logic [31:0]  irdata,
   output logic         iack,
   input  logic         dreq,
   input  logic         dwe,
   input  logic         dtype,
   input  logic [N-1:0] dadr,
   input  logic [N-1:0] dwdata,
   output logic [N-1:0] drdata,
   output logic         dack,
   output logic         mreq,
   output logic         mwe,
   output logic         mtype,
   output logic [N-1:0] madr,
   output logic [N-1:0] mwdata,
   input  logic [N-1:0] mrdata,
   input  logic         mready,
   output logic         istall,
   output logic         dstall,
   output logic         timeout
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      IFETCH = 2'd1,
      DATA   = 2'd2
   } state_t;

   localparam logic [7:0] TMO_CNT = 8'(TMO_CYCLES);

   state_t         state_q;
   logic [N-1:0]   adr_q;
   logic [N-1:0]   wdata_q;
   logic           we_q;
   logic           type_q;
   logic [7:0]     cnt_q;
   logic           timeout_q;

   logic           busy;
   logic           done;
   logic           tmo_hit;
   logic           pick_data_d;

   assign busy    = (state_q != IDLE);
   // mready in the terminal-count cycle is a normal completion, not an abort
   assign tmo_hit = busy && (cnt_q == TMO_CNT) && !mready;
   assign done    = busy && (mready || (cnt_q == TMO_CNT));

   assign iack    = (state_q == IFETCH) && done;
   assign dack    = (state_q == DATA) && done;
   assign irdata  = tmo_hit ? 32'd0 : mrdata[31:0];
   assign drdata  = tmo_hit ? '0 : mrdata;

   assign istall  = ireq & ~iack;
   assign dstall  = dreq & ~dack;

   assign mreq    = busy;
   assign mwe     = we_q;
   assign mtype   = type_q;
   assign madr    = adr_q;
   assign mwdata  = wdata_q;
   assign timeout = timeout_q;

`ifdef MEMARB_RR_EN
   // 1 = last completed transaction was a data access
   logic last_q;

   always_comb begin
      pick_data_d = dreq & (~ireq | ~last_q);
   end
`else
   always_comb begin
      pick_data_d = dreq;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         adr_q     <= '0;
         wdata_q   <= '0;
         we_q      <= 1'b0;
         type_q    <= 1'b0;
         cnt_q     <= 8'd0;
         timeout_q <= 1'b0;
`ifdef MEMARB_RR_EN
         last_q    <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               cnt_q <= 8'd0;
               if (pick_data_d) begin
                  state_q <= DATA;
                  adr_q   <= dadr;
                  wdata_q <= dwdata;
                  we_q    <= dwe;
                  type_q  <= dtype;
               end else if (ireq) begin
                  state_q <= IFETCH;
                  adr_q   <= N'(iadr);
                  wdata_q <= '0;
                  we_q    <= 1'b0;
                  type_q  <= 1'b0;
               end
            end
            default: begin
               if (done) begin
                  state_q <= IDLE;
                  if (tmo_hit) begin
                     timeout_q <= 1'b1;
                  end
`ifdef MEMARB_RR_EN
                  last_q <= (state_q == DATA);
`endif
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
         endcase
      end
   end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: N, 64, data/address width of data port and memory port.
REQ-002 Parameter: TMO_CYCLES, 255, busy cycles without mready before abort (range 1..255, 8-bit counter).
REQ-003 clk  in  1  clock; all state updates on rising edge.
REQ-004 reset  in  1  reset, asynchronous and active-high.
REQ-005 ireq  in  1  instruction fetch request, held until iack.
REQ-006 iadr  in  32  fetch address.
REQ-007 irdata  out  32  fetch data, mrdata[31:0], valid when iack=1.
REQ-008 iack  out  1  one-cycle fetch completion pulse.
REQ-009 dreq  in  1  data request, held until dack.
REQ-010 dwe  in  1  1=write, 0=read.
REQ-011 dtype  in  1  1=doubleword, 0=word.
REQ-012 dadr, dwdata  in  N each  data address, write data.
REQ-013 drdata  out  N  read data, mrdata, valid when dack=1.
REQ-014 dack  out  1  one-cycle data completion pulse.
REQ-015 mreq, mwe, mtype  out  1 each  memory request, write enable, size.
REQ-016 madr, mwdata  out  N each  memory address (fetch: iadr zero-extended), write data.
REQ-017 mrdata  in  N, mready  in  1  memory read data, completion strobe.
REQ-018 istall, dstall  out  1 each  ireq&~iack, dreq&~dack (combinational).
REQ-019 timeout  out  1  sticky abort flag.

Function
REQ-020 FSM states IDLE, IFETCH, DATA; mreq=1 exactly in IFETCH and DATA.
REQ-021 IDLE: dreq -> DATA; else ireq -> IFETCH; else stay IDLE (default arbitration: data wins).
REQ-022 On grant edge, latch address, wdata, we, type of winner; madr/mwdata/mwe/mtype driven only from latches, stable for whole transaction; mwe=0 in IFETCH.
REQ-023 Busy state with mready=1: matching ack=1 same cycle (combinational), next state IDLE.
REQ-024 Minimum latency req->ack: 2 cycles (grant edge, mready in first busy cycle); one IDLE bubble between transactions.
REQ-025 Requester dropping req mid-transaction: transaction still completes, ack still pulses; no cancel.
REQ-026 Timeout counter cleared at grant, +1 per busy cycle with mready=0; when count==TMO_CYCLES: ack pulses with read data forced 0, timeout<=1, next state IDLE; mready in same cycle takes precedence (normal completion).
REQ-027 mready in IDLE ignored; iack and dack never both 1.

Reset
REQ-028 reset=1 forces immediately: state IDLE, mreq=0, iack=dack=0, latches 0, counter 0, timeout=0, last-grant=instruction.
REQ-029 Reset mid-transaction aborts it with no ack; memory must tolerate dropped mreq.

Configuration
REQ-030 Macro MEMARB_RR_EN: defined -> when dreq and ireq both high in IDLE, grant the requester not served by the last completed transaction (last-grant register, reset = instruction, so data first); single pending request granted as REQ-021.
REQ-031 MEMARB_RR_EN undefined -> fixed data priority, no last-grant register.

Verification
REQ-032 ireq=1 iadr=0x40, mready at 3rd busy cycle, mrdata=0x1234_5678 -> madr=0x40 mwe=0, iack one cycle, irdata=0x12345678, istall high until then.
REQ-033 dreq,dwe=1,dtype=1,dadr=0x80,dwdata=0xDEADBEEF_00000001, mready first busy cycle -> mwe=1 mtype=1, dack at cycle 2, back to IDLE.
REQ-034 dreq and ireq held together, immediate mready -> default: DATA,IDLE,DATA... ireq starved; MEMARB_RR_EN: DATA,IDLE,IFETCH,IDLE,DATA alternation.
REQ-035 TMO_CYCLES=4, dreq read, mready never -> dack after 4 busy cycles, drdata=0, timeout=1 and stays 1 until reset.
REQ-036 reset pulsed mid-DATA -> mreq=0 immediately, no dack, timeout=0, next ireq granted normally.
